// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-entry fetch buffer in front of a req/ack instruction memory.
// Optional fetch timeout with sticky error state is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned N          = 32,
  parameter int unsigned ADDR_SHIFT = 5,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc,
  input  logic         flush,
  output logic [N-1:0] instruction,
  output logic         instr_valid,
  output logic         stall,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         fetch_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, ERR} state_e;
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);
`else
  typedef enum logic [1:0] {IDLE, REQ} state_e;
`endif

  state_e       state_q, state_d;
  logic         buf_valid_q, buf_valid_d;
  logic [N-1:0] buf_tag_q, buf_tag_d;
  logic [N-1:0] buf_data_q, buf_data_d;
  logic [N-1:0] addr_q, addr_d;
  logic         drop_q, drop_d;
  logic         req_q, req_d;
  logic         hit;

`ifdef FETCH_TIMEOUT_EN
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          fetch_err_q, fetch_err_d;
  assign hit = buf_valid_q & (pc == buf_tag_q) & ~flush & (state_q != ERR);
  assign fetch_err = fetch_err_q;
`else
  assign hit = buf_valid_q & (pc == buf_tag_q) & ~flush;
  assign fetch_err = 1'b0;
`endif

  // Combinational handshake to the datapath; stall is forced low while in reset.
  assign instr_valid = hit;
  assign stall       = reset & ~hit;
  assign instruction = hit ? buf_data_q : '0;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q >> ADDR_SHIFT;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    addr_d      = addr_q;
    drop_d      = drop_q;
    req_d       = req_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = fetch_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          buf_valid_d = 1'b0;
        end else if (!hit) begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      REQ: begin
        if (imem_ack) begin
          // A flush on the ack cycle, or one seen earlier, discards the response.
          if (!drop_q && !flush) begin
            buf_data_d  = imem_rdata;
            buf_tag_d   = addr_q;
            buf_valid_d = 1'b1;
          end else begin
            buf_valid_d = 1'b0;
          end
          drop_d  = 1'b0;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          if (flush) drop_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_LAST) begin
            req_d       = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = ERR;
          end
`endif
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ERR: begin
        req_d = 1'b0;
      end
`endif

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      addr_q      <= '0;
      drop_q      <= 1'b0;
      req_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      req_q       <= req_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  // NOTE: buffer tag/data need no reset; buf_valid_q gates every use of them.
  always_ff @(posedge clk) begin
    buf_tag_q  <= buf_tag_d;
    buf_data_q <= buf_data_d;
  end

endmodule
